esm_issue_sched: RTL and testbench

Issue scheduler sitting directly downstream of the instruction register table. It owns the `bs`-entry instruction buffer slots and hands out the free slot index that the table uses as `buffer_index`. It captures the table's registered dependency vector `idt` one cycle later, tracks per-slot dependencies as a matrix, and issues dependency-free instructions over a valid/ready handshake. Completions clear dependency columns and free slots for reuse.

---
 rtl/esm_issue_sched.sv | 187 ++++++++++++++++++
 tb/tb_esm_issue_sched.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/esm_issue_sched.sv
// esm_issue_sched
// Issue scheduler for the instruction buffer. It owns the bs slots, hands the
// lowest free slot to the dependency table as its buffer index, captures the
// table's dependency vector one cycle after acceptance, and offers
// dependency-free slots to the consumer over a valid/ready handshake.
// Completions free slots and clear their dependency columns.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   alloc_idx       lowest free slot (table buffer_index)
//   alloc_ready     at least one slot is free
//   in_valid        new instruction offered (accepted when alloc_ready)
//   idt             dependency vector, valid the cycle after acceptance
//   issue_valid     a slot is ready to issue
//   issue_idx       slot being offered
//   issue_ready     consumer takes issue_idx
//   done_valid      completion strobe
//   done_idx        completing slot
//   occ_count       number of non-free slots
//
// Configuration macro:
//   ESM_ISSUE_RR_EN  round-robin issue selection; otherwise lowest ready index.
//
// All outputs are decoded from registered state only.
module esm_issue_sched #(
  parameter int bs = 16,
  localparam int IW = $clog2(bs),
  localparam int CW = $clog2(bs + 1)
) (
  input  logic          clk,
  input  logic          rst,
  output logic [IW-1:0] alloc_idx,
  output logic          alloc_ready,
  input  logic          in_valid,
  input  logic [bs-1:0] idt,
  output logic          issue_valid,
  output logic [IW-1:0] issue_idx,
  input  logic          issue_ready,
  input  logic          done_valid,
  input  logic [IW-1:0] done_idx,
  output logic [CW-1:0] occ_count
);

  localparam logic [1:0] ST_FREE   = 2'd0;
  localparam logic [1:0] ST_RESV   = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_ISSUED = 2'd3;

  localparam logic [IW-1:0] IDX_ONE = IW'(1);
  localparam logic [bs-1:0] BIT0    = {{(bs-1){1'b0}}, 1'b1};

  logic [1:0]    state_r [bs];
  logic [bs-1:0] row_r   [bs];
  logic          cap_valid_r;
  logic [IW-1:0] cap_idx_r;

  logic [bs-1:0] free_s;
  logic [bs-1:0] occ_s;
  logic [bs-1:0] ready_s;
  logic [bs-1:0] clear_col_s;
  logic [bs-1:0] cap_self_s;
  logic [IW-1:0] sel_idx_s;
  logic          accept_s;
  logic          issue_fire_s;
  logic          done_fire_s;

  // Index of the lowest set bit; zero when the vector is empty.
  function automatic logic [IW-1:0] lowest_one(input logic [bs-1:0] vec);
    logic [IW-1:0] idx;
    idx = {IW{1'b0}};
    for (int i = bs - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = IW'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Number of set bits.
  function automatic logic [CW-1:0] pop_count(input logic [bs-1:0] vec);
    logic [CW-1:0] cnt;
    cnt = {CW{1'b0}};
    for (int i = 0; i < bs; i++) begin
      cnt = cnt + {{(CW-1){1'b0}}, vec[i]};
    end
    return cnt;
  endfunction

  // Per-slot status vectors decoded from the slot state and dependency rows.
  always_comb begin
    free_s  = {bs{1'b0}};
    occ_s   = {bs{1'b0}};
    ready_s = {bs{1'b0}};
    for (int i = 0; i < bs; i++) begin
      free_s[i]  = (state_r[i] == ST_FREE);
      occ_s[i]   = (state_r[i] != ST_FREE);
      ready_s[i] = (state_r[i] == ST_WAIT) && (row_r[i] == {bs{1'b0}});
    end
  end

`ifdef ESM_ISSUE_RR_EN
  logic [IW-1:0]   rr_ptr_r;
  logic [2*bs-1:0] rr_dbl_s;

  // Rotate the ready vector so the search starts at the pointer, then
  // translate the winner back to an absolute index (IW-bit add wraps).
  always_comb begin
    rr_dbl_s  = {ready_s, ready_s} >> rr_ptr_r;
    sel_idx_s = lowest_one(rr_dbl_s[bs-1:0]) + rr_ptr_r;
  end

  // Round-robin pointer: one past the last slot handed to the consumer.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_r <= {IW{1'b0}};
    end else if (issue_fire_s) begin
      rr_ptr_r <= issue_idx + IDX_ONE;
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end
`else
  // Fixed priority: the lowest ready slot wins.
  always_comb begin
    sel_idx_s = lowest_one(ready_s);
  end
`endif

  assign alloc_ready = |free_s;
  assign alloc_idx   = lowest_one(free_s);
  assign issue_valid = |ready_s;
  assign issue_idx   = issue_valid ? sel_idx_s : {IW{1'b0}};
  assign occ_count   = pop_count(occ_s);

  // Handshake qualifiers; a completion only counts for an issued slot.
  always_comb begin
    accept_s     = in_valid && alloc_ready;
    issue_fire_s = issue_valid && issue_ready;
    done_fire_s  = done_valid && (state_r[done_idx] == ST_ISSUED);
    if (done_fire_s) begin
      clear_col_s = BIT0 << done_idx;
    end else begin
      clear_col_s = {bs{1'b0}};
    end
    cap_self_s = BIT0 << cap_idx_r;
  end

  // Slot state, dependency rows and the one-deep capture register.
  // Accept, capture, issue and completion always target distinct slots
  // because each requires a different current state.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < bs; i++) begin
        state_r[i] <= ST_FREE;
        row_r[i]   <= {bs{1'b0}};
      end
      cap_valid_r <= 1'b0;
      cap_idx_r   <= {IW{1'b0}};
    end else begin
      for (int i = 0; i < bs; i++) begin
        if (accept_s && (alloc_idx == IW'(i))) begin
          state_r[i] <= ST_RESV;
        end else if (cap_valid_r && (cap_idx_r == IW'(i))) begin
          state_r[i] <= ST_WAIT;
        end else if (issue_fire_s && (issue_idx == IW'(i))) begin
          state_r[i] <= ST_ISSUED;
        end else if (done_fire_s && (done_idx == IW'(i))) begin
          state_r[i] <= ST_FREE;
        end else begin
          state_r[i] <= state_r[i];
        end
        // The occupancy mask drops the table's stale reset content and any
        // dependency on a slot completing on this same edge.
        if (cap_valid_r && (cap_idx_r == IW'(i))) begin
          row_r[i] <= idt & occ_s & ~cap_self_s & ~clear_col_s;
        end else begin
          row_r[i] <= row_r[i] & ~clear_col_s;
        end
      end
      cap_valid_r <= accept_s;
      cap_idx_r   <= accept_s ? alloc_idx : cap_idx_r;
    end
  end

endmodule

// File: tb/tb_esm_issue_sched.sv
module tb_esm_issue_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  alloc_idx;
  logic        alloc_ready;
  logic        in_valid;
  logic [15:0] idt;
  logic        issue_valid;
  logic [3:0]  issue_idx;
  logic        issue_ready;
  logic        done_valid;
  logic [3:0]  done_idx;
  logic [4:0]  occ_count;

  int checks = 0;
  int errors = 0;

  esm_issue_sched dut (
    .clk(clk), .rst(rst),
    .alloc_idx(alloc_idx), .alloc_ready(alloc_ready),
    .in_valid(in_valid), .idt(idt),
    .issue_valid(issue_valid), .issue_idx(issue_idx), .issue_ready(issue_ready),
    .done_valid(done_valid), .done_idx(done_idx),
    .occ_count(occ_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [15:0] idt;
    logic        ir;
    logic        dv;
    logic [3:0]  di;
    logic        e_ar;
    logic [3:0]  e_ai;
    logic        e_iv;
    logic [3:0]  e_ii;
    logic [4:0]  e_occ;
  } vec_t;

  vec_t tbl[8];

  // reference model: slot status 0 free, 1 reserved, 2 waiting, 3 issued
  int        m_st[16];
  bit [15:0] m_dep[16];
  bit        m_cap;
  int        m_cap_slot;
  int        m_ptr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string name, input logic ar, input int ai, input logic iv,
                          input int ii, input int occ);
    chk({name, ".alloc_ready"}, alloc_ready, ar);
    chk({name, ".alloc_idx"}, alloc_idx, ai);
    chk({name, ".issue_valid"}, issue_valid, iv);
    chk({name, ".issue_idx"}, issue_idx, ii);
    chk({name, ".occ_count"}, occ_count, occ);
  endtask

  task automatic drive(input logic iv, input logic [15:0] d, input logic ir,
                       input logic dv, input int di);
    in_valid    = iv;
    idt         = d;
    issue_ready = ir;
    done_valid  = dv;
    done_idx    = di[3:0];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 16'hFFFF, 1'b0, 1'b0, 0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_st[i]  = 0;
      m_dep[i] = 16'h0000;
    end
    m_cap = 1'b0;
    m_cap_slot = 0;
    m_ptr = 0;
  endtask

  task automatic model_out(output bit ar, output int ai, output bit iv, output int ii,
                           output int occ);
    int j;
    ar = 1'b0; ai = 0; occ = 0; iv = 1'b0; ii = 0;
    for (int i = 15; i >= 0; i--) begin
      if (m_st[i] == 0) begin
        ar = 1'b1;
        ai = i;
      end
    end
    for (int i = 0; i < 16; i++) if (m_st[i] != 0) occ++;
    for (int k = 0; k < 16; k++) begin
`ifdef ESM_ISSUE_RR_EN
      j = (m_ptr + k) % 16;
`else
      j = k;
`endif
      if (!iv && m_st[j] == 2 && m_dep[j] == 16'h0000) begin
        iv = 1'b1;
        ii = j;
      end
    end
  endtask

  task automatic model_step(input bit r, input bit iv, input bit [15:0] d, input bit ir,
                            input bit dv, input int di, input bit p_ar, input int p_ai,
                            input bit p_iv, input int p_ii);
    int        nst[16];
    bit [15:0] ndep[16];
    bit        done_ok;
    if (r) begin
      model_reset();
      return;
    end
    done_ok = dv && (m_st[di] == 3);
    nst = m_st;
    ndep = m_dep;
    if (m_cap) begin
      for (int j = 0; j < 16; j++)
        ndep[m_cap_slot][j] = d[j] && (j != m_cap_slot) && (m_st[j] != 0) && !(done_ok && j == di);
      nst[m_cap_slot] = 2;
    end
    if (done_ok) begin
      nst[di] = 0;
      for (int i = 0; i < 16; i++) ndep[i][di] = 1'b0;
    end
    if (p_iv && ir) begin
      nst[p_ii] = 3;
      m_ptr = (p_ii + 1) % 16;
    end
    if (iv && p_ar) begin
      nst[p_ai] = 1;
      m_cap = 1'b1;
      m_cap_slot = p_ai;
    end else begin
      m_cap = 1'b0;
    end
    m_st = nst;
    m_dep = ndep;
  endtask

  initial begin
    int        order[3];
    bit [15:0] c_idt[10];
    bit        p_ar, p_iv, r_rst, r_iv, r_ir, r_dv;
    int        p_ai, p_ii, p_occ, r_di, n_iss;
    int        iss[16];
    bit [15:0] r_idt;

    // {iv, idt, ir, dv, di, exp alloc_ready, alloc_idx, issue_valid, issue_idx, occ}
    tbl[0] = '{1'b0, 16'hFFFF, 1'b0, 1'b0, 4'd0, 1'b1, 4'd0, 1'b0, 4'd0, 5'd0};
    tbl[1] = '{1'b1, 16'hFFFF, 1'b0, 1'b0, 4'd0, 1'b1, 4'd1, 1'b0, 4'd0, 5'd1};
    tbl[2] = '{1'b1, 16'h0000, 1'b0, 1'b0, 4'd0, 1'b1, 4'd2, 1'b1, 4'd0, 5'd2};
    tbl[3] = '{1'b0, 16'h0001, 1'b0, 1'b0, 4'd0, 1'b1, 4'd2, 1'b1, 4'd0, 5'd2};
    tbl[4] = '{1'b0, 16'h0000, 1'b1, 1'b0, 4'd0, 1'b1, 4'd2, 1'b0, 4'd0, 5'd2};
    tbl[5] = '{1'b0, 16'h0000, 1'b0, 1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 4'd1, 5'd1};
    tbl[6] = '{1'b0, 16'h0000, 1'b1, 1'b0, 4'd0, 1'b1, 4'd0, 1'b0, 4'd0, 5'd1};
    tbl[7] = '{1'b0, 16'h0000, 1'b0, 1'b1, 4'd1, 1'b1, 4'd0, 1'b0, 4'd0, 5'd0};

    do_reset();
    chk_outs("reset", 1'b1, 0, 1'b0, 0, 0);
    for (int v = 0; v < 8; v++) begin
      drive(tbl[v].iv, tbl[v].idt, tbl[v].ir, tbl[v].dv, int'(tbl[v].di));
      tick();
      chk_outs($sformatf("vec%0d", v), tbl[v].e_ar, int'(tbl[v].e_ai), tbl[v].e_iv,
               int'(tbl[v].e_ii), int'(tbl[v].e_occ));
    end

    // fill all slots, overflow attempt, spurious completion, then free one
    do_reset();
    for (int k = 0; k < 16; k++) begin
      drive(1'b1, 16'h0000, 1'b0, 1'b0, 0);
      tick();
      chk("fill.occ", occ_count, k + 1);
      chk("fill.alloc_ready", alloc_ready, (k < 15) ? 1 : 0);
      if (k < 15) chk("fill.alloc_idx", alloc_idx, k + 1);
    end
    drive(1'b1, 16'h0000, 1'b0, 1'b0, 0);
    tick();
    chk_outs("full", 1'b0, 0, 1'b1, 0, 16);
    drive(1'b1, 16'hFFFF, 1'b0, 1'b0, 0);
    tick();
    chk_outs("full.ignored", 1'b0, 0, 1'b1, 0, 16);
    drive(1'b0, 16'h0000, 1'b0, 1'b1, 5);
    tick();
    chk_outs("done_on_wait", 1'b0, 0, 1'b1, 0, 16);
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, 16'h0000, 1'b1, 1'b0, 0);
      chk("issue_seq.valid", issue_valid, 1);
      chk("issue_seq.idx", issue_idx, k);
      tick();
    end
    drive(1'b0, 16'h0000, 1'b0, 1'b1, 1);
    tick();
    chk_outs("free_one", 1'b1, 1, 1'b1, 6, 15);

    // capture on the same edge as the completion of a dependency
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 16'h0000, 1'b0, 1'b0, 0);
      tick();
    end
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 0);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 16'h0000, 1'b1, 1'b0, 0);
      chk("same_edge.issue_idx", issue_idx, k);
      tick();
    end
    drive(1'b0, 16'h0000, 1'b0, 1'b1, 2);
    tick();
    chk_outs("same_edge.free2", 1'b1, 2, 1'b0, 0, 3);
    drive(1'b1, 16'h0000, 1'b0, 1'b0, 0);
    tick();
    chk_outs("same_edge.accept", 1'b1, 4, 1'b0, 0, 4);
    drive(1'b0, 16'h0008, 1'b0, 1'b1, 3);
    tick();
    chk_outs("same_edge.capture", 1'b1, 3, 1'b1, 2, 3);

    // selection order with slots 1, 4, 9 ready
    do_reset();
    c_idt[0] = 16'h0000; c_idt[1] = 16'h0001; c_idt[2] = 16'h0002; c_idt[3] = 16'h0002;
    c_idt[4] = 16'h0000; c_idt[5] = 16'h0002; c_idt[6] = 16'h0002; c_idt[7] = 16'h0002;
    c_idt[8] = 16'h0002; c_idt[9] = 16'h0001;
    for (int k = 0; k <= 10; k++) begin
      drive((k < 10) ? 1'b1 : 1'b0, (k > 0) ? c_idt[k-1] : 16'h0000, 1'b0, 1'b0, 0);
      tick();
    end
    chk_outs("order.filled", 1'b1, 10, 1'b1, 0, 10);
    drive(1'b0, 16'h0000, 1'b1, 1'b0, 0);
    tick();
    chk_outs("order.after0", 1'b1, 10, 1'b1, 4, 10);
    tick();
    chk_outs("order.after4", 1'b1, 10, 1'b0, 0, 10);
    drive(1'b0, 16'h0000, 1'b0, 1'b1, 4);
    tick();
    chk("order.free4", alloc_idx, 4);
    drive(1'b1, 16'h0000, 1'b0, 1'b1, 0);
    tick();
    chk("order.refill_occ", occ_count, 9);
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 0);
    tick();
`ifdef ESM_ISSUE_RR_EN
    order[0] = 9; order[1] = 1; order[2] = 4;
`else
    order[0] = 1; order[1] = 4; order[2] = 9;
`endif
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 16'h0000, 1'b1, 1'b0, 0);
      chk("order.valid", issue_valid, 1);
      chk("order.idx", issue_idx, order[k]);
      tick();
    end
    chk("order.drained", issue_valid, 0);

    // randomized traffic against the reference model
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      model_out(p_ar, p_ai, p_iv, p_ii, p_occ);
      chk_outs("rand", p_ar, p_ai, p_iv, p_ii, p_occ);
      r_rst = ($urandom_range(0, 199) == 0);
      r_iv  = ($urandom_range(0, 9) < 6);
      r_idt = 16'($urandom & $urandom);
      r_ir  = $urandom_range(0, 1);
      n_iss = 0;
      for (int i = 0; i < 16; i++) if (m_st[i] == 3) begin iss[n_iss] = i; n_iss++; end
      r_dv = 1'b0;
      r_di = $urandom_range(0, 15);
      if (n_iss > 0 && $urandom_range(0, 2) == 0) begin
        r_dv = 1'b1;
        r_di = iss[$urandom_range(0, n_iss - 1)];
      end else if (!m_cap && $urandom_range(0, 15) == 0) begin
        r_dv = 1'b1;
      end
      rst = r_rst;
      drive(r_iv, r_idt, r_ir, r_dv, r_di);
      model_step(r_rst, r_iv, r_idt, r_ir, r_dv, r_di, p_ar, p_ai, p_iv, p_ii);
      tick();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
